// File: rtl/maxpool_pkg.sv
// rtl/maxpool_pkg.sv - shared pixel type, controller states and 4-way signed max
package maxpool_pkg;

  typedef logic signed [7:0] pix_t;

  localparam pix_t PIX_MIN = 8'sh80;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  function automatic pix_t max4(input pix_t a, input pix_t b, input pix_t c, input pix_t d);
    pix_t m_ab;
    pix_t m_cd;
    m_ab = (a > b) ? a : b;
    m_cd = (c > d) ? c : d;
    return (m_ab > m_cd) ? m_ab : m_cd;
  endfunction

endpackage

// File: rtl/maxpool_linebuf.sv
// rtl/maxpool_linebuf.sv - 2x2 window line buffer: one row plus two pixels of raster history
module maxpool_linebuf
  import maxpool_pkg::*;
#(
  parameter int LENGTH = 28
) (
  input  logic clk,
  input  logic rst_n,
  input  logic data_valid_in,
  input  pix_t data_in,
  output pix_t win_00,
  output pix_t win_01,
  output pix_t win_10,
  output pix_t win_11
);

  localparam int DEPTH = LENGTH + 2;

  pix_t tap_q [DEPTH];
  pix_t tap_d [DEPTH];

  always_comb begin
    tap_d = tap_q;
    if (data_valid_in) begin
      tap_d[0] = data_in;
      for (int i = 1; i < DEPTH; i++) begin
        tap_d[i] = tap_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tap_q[i] <= PIX_MIN;
      end
    end else begin
      tap_q <= tap_d;
    end
  end

  // Tap k holds the pixel k positions back in raster order; LENGTH back is one row up.
  assign win_11 = tap_q[0];
  assign win_10 = tap_q[1];
  assign win_01 = tap_q[LENGTH];
  assign win_00 = tap_q[LENGTH+1];

endmodule

// File: rtl/maxpool_ctrl.sv
// rtl/maxpool_ctrl.sv - frame controller for 2x2 stride-2 signed 8-bit max pooling
module maxpool_ctrl
  import maxpool_pkg::*;
#(
  parameter int WIDTH  = 28,
  parameter int HEIGHT = 28
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic in_valid,
  output logic in_ready,
  input  pix_t pixel_in,
  output logic out_valid,
  input  logic out_ready,
  output pix_t pool_out,
  output logic out_last,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          pend_q, pend_d;
  logic          out_valid_q, out_valid_d;
  pix_t          pool_q, pool_d;
  logic          last_q, last_d;
  logic          done_q, done_d;

  logic accept;
  logic col_wrap;
  logic out_hs;
  pix_t win_00, win_01, win_10, win_11;

  assign in_ready = (state_q == RUN) & !pend_q & !(out_valid_q & !out_ready);
  assign accept   = in_valid & in_ready;
  assign col_wrap = (col_q == COL_LAST);
  assign out_hs   = out_valid_q & out_ready;

  maxpool_linebuf #(
    .LENGTH(WIDTH)
  ) u_linebuf (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_valid_in(accept),
    .data_in      (pixel_in),
    .win_00       (win_00),
    .win_01       (win_01),
    .win_10       (win_10),
    .win_11       (win_11)
  );

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    pend_d      = accept & row_q[0] & col_q[0];
    out_valid_d = out_valid_q;
    pool_d      = pool_q;
    last_d      = last_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          col_d   = '0;
          row_d   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          col_d = col_wrap ? '0 : col_q + CW'(1);
          if (col_wrap) begin
            row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            if (row_q == ROW_LAST) begin
              state_d = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (out_hs && last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The final window always completes on the accept that enters DRAIN.
    if (pend_q) begin
      out_valid_d = 1'b1;
      pool_d      = max4(win_00, win_01, win_10, win_11);
      last_d      = (state_q == DRAIN);
    end else if (out_hs) begin
      out_valid_d = 1'b0;
      last_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      pool_q      <= PIX_MIN;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      pool_q      <= pool_d;
      last_q      <= last_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign pool_out  = pool_q;
  assign out_last  = last_q;
  assign busy      = (state_q == RUN) | (state_q == DRAIN);
  assign done      = done_q;

endmodule
